dot_seq_ctrl: RTL and testbench

- Sequencer for one multiply-accumulate datapath unit: takes a dot-product command, issues operand reads to two registered operand memories, and gates the returned data into the MAC.
- Clears the MAC before each command and captures the final sum.
- Presents the sum on a valid/ready result port.
- Sits between the command source, the operand SRAMs and the MAC instance in the classifier dot-product path.

---
 rtl/dot_seq_ctrl_if.sv | 44 ++++
 rtl/dot_seq_ctrl.sv | 112 +++++++++++
 tb/tb_dot_seq_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_seq_ctrl_if.sv
// Command, operand-memory, MAC and result signals of the dot-product sequencer.
// The abort input exists only when DOT_SEQ_CTRL_ABORT_EN is defined.
interface dot_seq_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] vec_len;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;
  logic              busy;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] mem_data_a;
  logic [DATA_W-1:0] mem_data_b;
  logic              mac_clr;
  logic [DATA_W-1:0] mac_a;
  logic [DATA_W-1:0] mac_b;
  logic [DATA_W-1:0] mac_sum;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              result_ready;
`ifdef DOT_SEQ_CTRL_ABORT_EN
  logic              abort;
`endif

  // Environment side: command source, operand memories, MAC and result consumer.
  modport master (
    output start, vec_len, base_a, base_b, mem_data_a, mem_data_b, mac_sum, result_ready,
    input  busy, rd_en, rd_addr_a, rd_addr_b, mac_clr, mac_a, mac_b, result, result_valid
`ifdef DOT_SEQ_CTRL_ABORT_EN
    , output abort
`endif
  );

  modport slave (
    input  start, vec_len, base_a, base_b, mem_data_a, mem_data_b, mac_sum, result_ready,
    output busy, rd_en, rd_addr_a, rd_addr_b, mac_clr, mac_a, mac_b, result, result_valid
`ifdef DOT_SEQ_CTRL_ABORT_EN
    , input abort
`endif
  );
endinterface

// File: rtl/dot_seq_ctrl.sv
// Dot-product sequencer: clears the MAC, streams operand reads, gates returned data into the MAC
// and holds the final sum on a valid/ready port. Optional abort: DOT_SEQ_CTRL_ABORT_EN.
module dot_seq_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned MEM_LAT = 1
) (
  input logic           clk,
  input logic           reset,
  dot_seq_ctrl_if.slave io_bus
);

  typedef enum logic [2:0] {StIdle, StClear, StIssue, StDrain, StHold} state_e;

  localparam logic [ADDR_W-1:0] AddrOne   = 1;
  localparam logic [2:0]        DrainLast = 3'(MEM_LAT);
  localparam logic [2:0]        CntOne    = 3'd1;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_base_a;
  logic [ADDR_W-1:0]   r_base_b;
  logic [ADDR_W-1:0]   r_len;
  logic [ADDR_W-1:0]   r_idx;
  logic [2:0]          r_drain_cnt;
  logic [MEM_LAT-1:0]  r_vld;
  logic [DATA_W-1:0]   r_result;
  logic                w_rd_en;
  logic                w_abort;
  logic                w_active;

  assign w_active = (r_state == StClear) || (r_state == StIssue) || (r_state == StDrain);

`ifdef DOT_SEQ_CTRL_ABORT_EN
  assign w_abort = io_bus.abort && w_active;
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (io_bus.start) begin
          w_state_nxt = (io_bus.vec_len != '0) ? StClear : StHold;
        end
      end
      StClear: w_state_nxt = StIssue;
      StIssue: begin
        if (r_idx == r_len - AddrOne) w_state_nxt = StDrain;
      end
      StDrain: begin
        if (r_drain_cnt == DrainLast) w_state_nxt = StHold;
      end
      StHold: begin
        if (io_bus.result_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
    // Abort wins over any transition taken in the same cycle.
    if (w_abort) w_state_nxt = StIdle;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_base_a    <= '0;
      r_base_b    <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_drain_cnt <= '0;
      r_result    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= (r_state == StIssue) ? r_idx + AddrOne : '0;
      r_drain_cnt <= (r_state == StDrain) ? r_drain_cnt + CntOne : '0;
      if (r_state == StIdle && io_bus.start) begin
        r_base_a <= io_bus.base_a;
        r_base_b <= io_bus.base_b;
        r_len    <= io_bus.vec_len;
        if (io_bus.vec_len == '0) r_result <= '0;
      end
      if (r_state == StDrain && r_drain_cnt == DrainLast && !w_abort) begin
        r_result <= io_bus.mac_sum;
      end
    end
  end

  // Tracks which cycles carry real read data back from the memories.
  always_ff @(posedge clk) begin
    if (reset || w_abort) begin
      r_vld <= '0;
    end else begin
      r_vld <= MEM_LAT'({r_vld, w_rd_en});
    end
  end

  assign w_rd_en = (r_state == StIssue);

  always_comb begin
    io_bus.busy         = (r_state != StIdle);
    io_bus.rd_en        = w_rd_en;
    io_bus.rd_addr_a    = w_rd_en ? r_base_a + r_idx : '0;
    io_bus.rd_addr_b    = w_rd_en ? r_base_b + r_idx : '0;
    io_bus.mac_clr      = (r_state == StClear) || w_abort;
    io_bus.mac_a        = r_vld[MEM_LAT-1] ? io_bus.mem_data_a : '0;
    io_bus.mac_b        = r_vld[MEM_LAT-1] ? io_bus.mem_data_b : '0;
    io_bus.result       = r_result;
    io_bus.result_valid = (r_state == StHold);
  end

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// Bench for dot_seq_ctrl: behavioural operand memories and MAC around the DUT, expected sums
// queued when each command is issued and checked when the result is accepted.
module tb_dot_seq_ctrl;
  localparam int unsigned DW      = 8;
  localparam int unsigned AW      = 8;
  localparam int unsigned MEM_LAT = 1;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  logic [DW-1:0] dly_a [MEM_LAT];
  logic [DW-1:0] dly_b [MEM_LAT];
  logic [DW-1:0] mac_q;
  logic [DW-1:0] prod_w;
  logic [DW-1:0] sb [$];

  dot_seq_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  dot_seq_ctrl #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .MEM_LAT(MEM_LAT)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    dly_a[0] <= mem_a[bus.rd_addr_a];
    dly_b[0] <= mem_b[bus.rd_addr_b];
    for (int i = 1; i < MEM_LAT; i++) begin
      dly_a[i] <= dly_a[i-1];
      dly_b[i] <= dly_b[i-1];
    end
  end
  assign bus.mem_data_a = dly_a[MEM_LAT-1];
  assign bus.mem_data_b = dly_b[MEM_LAT-1];

  // MAC model: wrapping accumulate, cleared by reset OR mac_clr.
  assign prod_w = bus.mac_a * bus.mac_b;
  always @(posedge clk) begin
    if (reset || bus.mac_clr) mac_q <= '0;
    else                      mac_q <= mac_q + prod_w;
  end
  assign bus.mac_sum = mac_q;

  task automatic do_cmd(input string name, input int len, input logic [AW-1:0] ba,
                        input logic [AW-1:0] bb, input int hold, input bit poke);
    logic [DW-1:0] acc, prod, exp_a, exp_b, exp_r;
    logic [AW-1:0] ea, eb;
    int exp_lat, k, idx, n_rd, n_clr;
    bit seen;
    acc = '0;
    for (int i = 0; i < len; i++) begin
      prod = mem_a[ba + AW'(i)] * mem_b[bb + AW'(i)];
      acc  = acc + prod;
    end
    sb.push_back(acc);
    exp_lat = (len == 0) ? 1 : len + int'(MEM_LAT) + 3;
    bus.result_ready = (hold == 0);
    bus.start   = 1'b1;
    bus.vec_len = AW'(len);
    bus.base_a  = ba;
    bus.base_b  = bb;
    @(negedge clk);
    bus.start = 1'b0;
    k = 1; seen = 1'b0; n_rd = 0; n_clr = 0;
    while (!seen && k <= 300) begin
      if (bus.rd_en) begin
        n_rd++;
        idx = k - 2;
        ea  = ba + AW'(idx);
        eb  = bb + AW'(idx);
        n_checks++;
        if (idx < 0 || idx >= len || bus.rd_addr_a !== ea || bus.rd_addr_b !== eb)
          $display("FAIL %s rd_addr cycle %0d: got a=%0h b=%0h, expected a=%0h b=%0h idx %0d/%0d",
                   name, k, bus.rd_addr_a, bus.rd_addr_b, ea, eb, idx, len);
        else n_pass++;
      end
      if (bus.mac_clr) n_clr++;
      idx = k - 2 - int'(MEM_LAT);
      if (idx >= 0 && idx < len) begin
        exp_a = mem_a[ba + AW'(idx)];
        exp_b = mem_b[bb + AW'(idx)];
      end else begin
        exp_a = '0;
        exp_b = '0;
      end
      n_checks++;
      if ({bus.mac_a, bus.mac_b} !== {exp_a, exp_b})
        $display("FAIL %s mac_ab cycle %0d: got %0h/%0h, expected %0h/%0h",
                 name, k, bus.mac_a, bus.mac_b, exp_a, exp_b);
      else n_pass++;
      if (bus.result_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    n_checks++;
    if (!seen) begin
      $display("FAIL %s timeout: result_valid never rose, expected at cycle %0d", name, exp_lat);
      void'(sb.pop_front());
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      return;
    end
    n_pass++;
    n_checks++;
    if (k !== exp_lat) $display("FAIL %s latency: got %0d, expected %0d", name, k, exp_lat);
    else n_pass++;
    n_checks++;
    if (n_rd !== len) $display("FAIL %s rd_count: got %0d, expected %0d", name, n_rd, len);
    else n_pass++;
    n_checks++;
    if (n_clr !== ((len != 0) ? 1 : 0))
      $display("FAIL %s clr_count: got %0d, expected %0d", name, n_clr, (len != 0) ? 1 : 0);
    else n_pass++;
    for (int h = 0; h < hold; h++) begin
      n_checks++;
      if (bus.result_valid !== 1'b1 || bus.result !== sb[0])
        $display("FAIL %s hold %0d: got valid=%0b result=%0h, expected valid=1 result=%0h",
                 name, h, bus.result_valid, bus.result, sb[0]);
      else n_pass++;
      if (poke && h == 1) begin
        bus.start   = 1'b1;
        bus.vec_len = 8'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.result_ready = 1'b1;
    exp_r = sb.pop_front();
    n_checks++;
    if (bus.result_valid !== 1'b1 || bus.result !== exp_r)
      $display("FAIL %s result: got valid=%0b result=%0h, expected valid=1 result=%0h",
               name, bus.result_valid, bus.result, exp_r);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0)
      $display("FAIL %s back_to_idle: got busy=%0b valid=%0b, expected 0/0",
               name, bus.busy, bus.result_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.vec_len = '0;
    bus.base_a = '0;
    bus.base_b = '0;
    bus.result_ready = 1'b0;
`ifdef DOT_SEQ_CTRL_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.rd_en, bus.result_valid, bus.mac_clr} !== 4'b0000 ||
          bus.mac_a !== '0 || bus.mac_b !== '0 || bus.result !== '0 ||
          bus.rd_addr_a !== '0 || bus.rd_addr_b !== '0)
        $display("FAIL reset_idle cycle %0d: got busy=%0b rd_en=%0b valid=%0b clr=%0b a=%0h b=%0h res=%0h, expected all 0",
                 c, bus.busy, bus.rd_en, bus.result_valid, bus.mac_clr, bus.mac_a, bus.mac_b,
                 bus.result);
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      mem_a[8'h10 + i] = DW'(i + 1);
      mem_b[8'h20 + i] = DW'(i + 5);
    end
    do_cmd("basic", 4, 8'h10, 8'h20, 0, 1'b0);
  endtask

  task automatic test_zero_len();
    do_cmd("zero_len", 0, 8'h10, 8'h20, 0, 1'b0);
  endtask

  task automatic test_wrap_hold();
    mem_a[8'h30] = 8'd16; mem_a[8'h31] = 8'd16;
    mem_b[8'h50] = 8'd16; mem_b[8'h51] = 8'd16;
    do_cmd("wrap_hold", 2, 8'h30, 8'h50, 5, 1'b1);
  endtask

  task automatic test_addr_wrap();
    mem_a[8'hFE] = 8'd3; mem_a[8'hFF] = 8'd7; mem_a[8'h00] = 8'd9; mem_a[8'h01] = 8'd2;
    for (int i = 0; i < 4; i++) mem_b[8'h40 + i] = DW'(i + 2);
    do_cmd("addr_wrap", 4, 8'hFE, 8'h40, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_cmd("b2b_first", 3, 8'h60, 8'h70, 0, 1'b0);
    do_cmd("b2b_second", 5, 8'h63, 8'h72, 2, 1'b0);
  endtask

  task automatic test_reset_mid();
    bus.start = 1'b1;
    bus.vec_len = 8'd8;
    bus.base_a = 8'h00;
    bus.base_b = 8'h08;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({bus.busy, bus.rd_en, bus.result_valid} !== 3'b000 || bus.result !== '0 ||
        bus.rd_addr_a !== '0)
      $display("FAIL reset_mid: got busy=%0b rd_en=%0b valid=%0b res=%0h addr=%0h, expected all 0",
               bus.busy, bus.rd_en, bus.result_valid, bus.result, bus.rd_addr_a);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.mac_a !== '0 || bus.busy !== 1'b0)
      $display("FAIL reset_mid_after: got mac_a=%0h busy=%0b, expected 0/0", bus.mac_a, bus.busy);
    else n_pass++;
  endtask

`ifdef DOT_SEQ_CTRL_ABORT_EN
  task automatic test_abort();
    bus.result_ready = 1'b1;
    bus.start = 1'b1;
    bus.vec_len = 8'd8;
    bus.base_a = 8'h80;
    bus.base_b = 8'h88;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    #1;
    n_checks++;
    if (bus.mac_clr !== 1'b1 || bus.rd_en !== 1'b1)
      $display("FAIL abort_clr: got mac_clr=%0b rd_en=%0b, expected 1/1", bus.mac_clr, bus.rd_en);
    else n_pass++;
    @(negedge clk);
    bus.abort = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.mac_clr !== 1'b0 || mac_q !== '0)
      $display("FAIL abort_idle: got busy=%0b clr=%0b sum=%0h, expected 0/0/0",
               bus.busy, bus.mac_clr, mac_q);
    else n_pass++;
    for (int c = 0; c < 6; c++) begin
      n_checks++;
      if (bus.result_valid !== 1'b0 || bus.mac_a !== '0)
        $display("FAIL abort_quiet cycle %0d: got valid=%0b mac_a=%0h, expected 0/0",
                 c, bus.result_valid, bus.mac_a);
      else n_pass++;
      @(negedge clk);
    end
    mem_a[8'h90] = 8'd11; mem_a[8'h91] = 8'd4;
    mem_b[8'hA0] = 8'd3;  mem_b[8'hA1] = 8'd5;
    do_cmd("after_abort", 2, 8'h90, 8'hA0, 0, 1'b0);
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass = 0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = DW'(i) ^ 8'h5A;
      mem_b[i] = DW'(i * 3) ^ 8'hC3;
    end
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap_hold();
    test_addr_wrap();
    test_back_to_back();
    test_reset_mid();
`ifdef DOT_SEQ_CTRL_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
